// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and helpers for the reg_file register bank.
package reg_file_pkg;

  localparam int REG_FILE_WIDTH = 32;
  localparam int REG_FILE_DEPTH = 8;

  // Address width needed to select one of 'depth' registers (never below 1 bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_file_reg_cell.sv
// reg_cell: one WIDTH-bit storage register with synchronous active-high
// reset, load enable, true and complemented outputs.
module reg_cell
  import reg_file_pkg::*;
#(
  parameter int WIDTH = REG_FILE_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  // Clear on reset, capture d when load is high, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

  assign q_n = ~q;

endmodule

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register bank, one synchronous write port and two
// registered read ports (A with complemented output, B).
// Optional build macro REG_FILE_BYPASS_EN: when defined, a read and a write to
// the same live address in one cycle returns the write data (forwarding);
// when undefined the read returns the previously stored value.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = REG_FILE_WIDTH,
  parameter int DEPTH    = REG_FILE_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_a_n,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] word [DEPTH];
  logic [WIDTH-1:0] word_n_unused [DEPTH];
  logic [WIDTH-1:0] rdata_b_n_unused;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;

  // An address is live when it names a real register that is not the
  // hardwired zero register; only live addresses are written or read.
  function automatic logic live(input logic [AW-1:0] addr);
    return ({1'b0, addr} < (AW+1)'(DEPTH)) &&
           !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Decode the write port into one load strobe per register.
  always_comb begin
    load = '0;
    for (int i = 0; i < DEPTH; i++) begin
      load[i] = we && live(waddr) && (waddr == AW'(i));
    end
  end

  // Storage: one reg_cell per register, all sharing the write data bus.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clock (clock),
      .reset (reset),
      .load  (load[i]),
      .d     (wdata),
      .q     (word[i]),
      .q_n   (word_n_unused[i])
    );
  end

  // Port A read mux: dead addresses return zero; same-address write is
  // forwarded only in the bypass build.
  always_comb begin
    next_a = '0;
    if (live(raddr_a)) begin
`ifdef REG_FILE_BYPASS_EN
      if (we && (raddr_a == waddr)) begin
        next_a = wdata;
      end else begin
        next_a = word[raddr_a];
      end
`else
      next_a = word[raddr_a];
`endif
    end else begin
      next_a = '0;
    end
  end

  // Port B read mux: same rules as port A.
  always_comb begin
    next_b = '0;
    if (live(raddr_b)) begin
`ifdef REG_FILE_BYPASS_EN
      if (we && (raddr_b == waddr)) begin
        next_b = wdata;
      end else begin
        next_b = word[raddr_b];
      end
`else
      next_b = word[raddr_b];
`endif
    end else begin
      next_b = '0;
    end
  end

  // Output registers: load on read enable, hold otherwise; q_n of port A
  // provides the complemented output straight from the flops.
  reg_cell #(.WIDTH(WIDTH)) u_port_a (
    .clock (clock),
    .reset (reset),
    .load  (re_a),
    .d     (next_a),
    .q     (rdata_a),
    .q_n   (rdata_a_n)
  );

  reg_cell #(.WIDTH(WIDTH)) u_port_b (
    .clock (clock),
    .reset (reset),
    .load  (re_b),
    .d     (next_b),
    .q     (rdata_b),
    .q_n   (rdata_b_n_unused)
  );

endmodule
